rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single write port of register_file between two writeback requesters: port 0 is the ALU writeback and port 1 is the load/immediate unit.
- Each requester uses a valid/ready handshake.
- The block drives write, rd_addr and data of register_file from registered outputs, so each register-file write lands one clock after its request is accepted.
- It also provides a synchronous flush for pipeline squash.

Parameters:
- DATA_WIDTH, 16, width of register data; must match register_file.
- ADDR_WIDTH, 3, register address width; 8 registers.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash; while high, no request is granted.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  ADDR_WIDTH  requester 0 destination register.
- req0_data  input  DATA_WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  ADDR_WIDTH  requester 1 destination register.
- req1_data  input  DATA_WIDTH  requester 1 write data.
- req1_ready  output  1  requester 1 accepted this cycle (combinational).
- rf_write  output  1  to register_file write.
- rf_rd_addr  output  ADDR_WIDTH  to register_file rd_addr.
- rf_data  output  DATA_WIDTH  to register_file data.
- grant_id  output  1  which requester owns the current rf_write cycle.
- write_count  output  16  total accepted writes; wraps from 0xFFFF to 0.

Behaviour:
- Reset (reset_n=0, asynchronous, effective immediately, including mid-transfer):
  - rf_write=0, rf_rd_addr=0, rf_data=0, grant_id=0, write_count=0.
  - Internal last_grant=1, so requester 0 wins the first contention.
  - A write that is in flight is dropped.
  - The ready outputs are 0 while reset is asserted.
- Handshake:
  - A transfer occurs on a rising edge where reqN_valid && reqN_ready.
  - reqN_ready = reqN_valid && grantN && !flush && reset_n.
  - At most one ready is high in any cycle.
  - A requester must hold addr and data stable while valid is high and ready is low.
  - A requester may drop valid only after its transfer.
- Arbitration (combinational, from valid inputs and last_grant):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - last_grant updates only on a transfer.
- Output stage (registered):
  - On the edge of a transfer: rf_write<=1, rf_rd_addr<=accepted addr, rf_data<=accepted data, grant_id<=N, write_count<=write_count+1.
  - On an edge with no transfer: rf_write<=0, and rf_rd_addr, rf_data, grant_id hold.
  - Latency: request accepted at edge K, rf_write high from K to K+1, register_file captures the data at edge K+1.
  - Back-to-back transfers give rf_write continuously high with a new address and data every cycle. Throughput is 1 write per clock.
- Flush:
  - No grant while flush=1; rf_write goes to 0 at the next edge.
  - A write already registered (rf_write=1 during the flush cycle) is still performed.
  - last_grant and write_count are unchanged.
- Address 0 is an ordinary writable register; there is no special-casing.
- Both requesters targeting the same address: writes are serialized in grant order, so the later grant wins.
- Behaviour of valid or addr inputs that are X while valid=0 is don't-care; X on valid is a bench error.

Optional Feature:
- Macro: RF_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as specified above.
- Undefined: fixed priority, requester 0 always wins contention. last_grant logic is removed. Requester 1 can be starved indefinitely while req0_valid stays high.
- All other behaviour, including latency, flush, reset and the counter, is identical in both builds.

Test Plan:
- After reset release, req0 only: addr=0, data=0x0001 -> req0_ready=1 in the same cycle; next cycle rf_write=1, rf_rd_addr=0, rf_data=0x0001, grant_id=0, write_count=1; register_file rs read of addr 0 returns 0x0001.
- Both valid for 4 cycles, req0 addr=1/0x1111 and req1 addr=7/0x00AB, each requester advancing to new data after every accept:
  - round-robin build: grant order 0,1,0,1 and rf_write high for 4 consecutive cycles, write_count=4;
  - fixed-priority build: order 0,0,0,0 and req1_ready stays 0.
- Both valid, both targeting addr=3, 0xAAAA and 0x5555 -> two sequential writes; register 3 ends with the second-granted value.
- flush=1 for 2 cycles with both requesters valid -> both ready signals 0, rf_write=0 from the next edge, write_count unchanged. After flush drops, arbitration resumes with the same last_grant.
- reset_n pulled low mid-stream while rf_write=1 -> rf_write, rf_rd_addr, rf_data and write_count read 0 immediately, before any clock edge. After release, requester 0 wins the first contention.
- Preload write_count to 0xFFFF via 65535 writes, then one more transfer -> write_count=0x0000.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter driving the single register_file write port.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  grant_id,
    output logic [15:0]           write_count
);

    logic grant0;
    logic grant1;
    logic xfer0;
    logic xfer1;
    logic xfer;

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= xfer1;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign req0_ready = req0_valid && grant0 && !flush && reset_n;
    assign req1_ready = req1_valid && grant1 && !flush && reset_n;
    assign xfer0      = req0_ready;
    assign xfer1      = req1_ready;
    assign xfer       = xfer0 || xfer1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_write    <= 1'b0;
            rf_rd_addr  <= '0;
            rf_data     <= '0;
            grant_id    <= 1'b0;
            write_count <= '0;
        end else if (xfer) begin
            rf_write    <= 1'b1;
            rf_rd_addr  <= xfer1 ? req1_addr : req0_addr;
            rf_data     <= xfer1 ? req1_data : req0_data;
            grant_id    <= xfer1;
            write_count <= write_count + 16'd1;
        end else begin
            rf_write    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, scoreboard,
// and hand sequences for flush, async reset, same-address and counter wrap.
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        rf_write;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_data;
    logic        grant_id;
    logic [15:0] write_count;

    rf_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .req0_valid(req0_valid),
        .req0_addr(req0_addr),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr(req1_addr),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .rf_write(rf_write),
        .rf_rd_addr(rf_rd_addr),
        .rf_data(rf_data),
        .grant_id(grant_id),
        .write_count(write_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic        fl;
        logic        r0;
        logic        r1;
    } vec_t;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic        g;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [15:0] exp_count = 16'd0;
    logic [2:0]  hold_addr = 3'd0;
    logic [15:0] hold_data = 16'd0;
    logic        hold_gid  = 1'b0;
    logic [15:0] regs [8];
    vec_t tbl [11];

    // Downstream register_file model
    always @(posedge clock)
        if (rf_write) regs[rf_rd_addr] <= rf_data;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [2:0] a0,
                                input logic [15:0] d0, input logic v1,
                                input logic [2:0] a1, input logic [15:0] d1,
                                input logic fl, input logic r0,
                                input logic r1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.fl = fl; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic check_outputs(input string nm);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_count = exp_count + 16'd1;
            hold_addr = e.a;
            hold_data = e.d;
            hold_gid  = e.g;
            chk({nm, ".rf_write"}, {31'd0, rf_write}, 32'd1);
        end else begin
            chk({nm, ".rf_write"}, {31'd0, rf_write}, 32'd0);
        end
        chk({nm, ".rf_rd_addr"}, {29'd0, rf_rd_addr}, {29'd0, hold_addr});
        chk({nm, ".rf_data"}, {16'd0, rf_data}, {16'd0, hold_data});
        chk({nm, ".grant_id"}, {31'd0, grant_id}, {31'd0, hold_gid});
        chk({nm, ".write_count"}, {16'd0, write_count}, {16'd0, exp_count});
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive_cycle(input vec_t v, input string nm);
        exp_t e;
        req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
        flush = v.fl;
        #1;
        chk({nm, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, v.r0});
        chk({nm, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, v.r1});
        if (v.r0) begin
            e.a = v.a0; e.d = v.d0; e.g = 1'b0;
            sb.push_back(e);
        end else if (v.r1) begin
            e.a = v.a1; e.d = v.d1; e.g = 1'b1;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        check_outputs(nm);
        @(negedge clock);
    endtask

    task automatic model_reset();
        sb.delete();
        exp_count = 16'd0;
        hold_addr = 3'd0;
        hold_data = 16'd0;
        hold_gid  = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic rr;
        int k0;
        int k1;
        int n;
`ifdef RF_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        tbl[0]  = mk(1, 3'd0, 16'h0001, 0, 3'd0, 16'h0000, 0, 1, 0);
        tbl[1]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0);
        tbl[2]  = mk(0, 3'd0, 16'h0000, 1, 3'd5, 16'h1234, 0, 0, 1);
        tbl[3]  = mk(1, 3'd2, 16'h2222, 1, 3'd6, 16'h6666, 0, 1, 0);
        tbl[4]  = mk(1, 3'd3, 16'h3333, 1, 3'd6, 16'h6666, 0, !rr, rr);
        tbl[5]  = mk(1, 3'd3, 16'h3333, 1, 3'd6, 16'h6677, 1, 0, 0);
        tbl[6]  = mk(1, 3'd3, 16'h3333, 1, 3'd6, 16'h6677, 1, 0, 0);
        tbl[7]  = mk(1, 3'd3, 16'h3333, 1, 3'd6, 16'h6677, 0, 1, 0);
        tbl[8]  = mk(0, 3'd0, 16'h0000, 1, 3'd0, 16'hBEEF, 0, 0, 1);
        tbl[9]  = mk(1, 3'd1, 16'h0101, 0, 3'd0, 16'h0000, 1, 0, 0);
        tbl[10] = mk(1, 3'd4, 16'h4444, 1, 3'd4, 16'h5555, 0, 1, 0);

        reset_n = 1'b0; flush = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        @(negedge clock);
        @(negedge clock);
        chk("reset.rf_write", {31'd0, rf_write}, 32'd0);
        chk("reset.write_count", {16'd0, write_count}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive_cycle(tbl[i], $sformatf("vec%0d", i));
            if (i == 1)
                chk("regfile.r0", {16'd0, regs[0]}, 32'h0001);
        end

        // Async reset while a write is registered
        v = mk(1, 3'd2, 16'h7777, 0, 3'd0, 16'h0, 0, 1, 0);
        drive_cycle(v, "pre_reset");
        chk("pre_reset.live", {31'd0, rf_write}, 32'd1);
        req1_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("async.rf_write", {31'd0, rf_write}, 32'd0);
        chk("async.rf_rd_addr", {29'd0, rf_rd_addr}, 32'd0);
        chk("async.rf_data", {16'd0, rf_data}, 32'd0);
        chk("async.write_count", {16'd0, write_count}, 32'd0);
        chk("async.req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("async.req1_ready", {31'd0, req1_ready}, 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Four cycles of contention, each side advancing after its accept
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 4; i++) begin
            logic g1;
            g1 = rr && (i % 2 == 1);
            v = mk(1, 3'd1, 16'h1111 + 16'(k0), 1, 3'd7, 16'h00AB + 16'(k1),
                   0, !g1, g1);
            drive_cycle(v, $sformatf("contend%0d", i));
            if (g1) k1++;
            else k0++;
        end
        chk("contend.count", {16'd0, write_count}, 32'd4);

        // Same destination: the later grant must win
        v = mk(1, 3'd3, 16'hAAAA, 1, 3'd3, 16'h5555, 0, 1, 0);
        drive_cycle(v, "same0");
        v = mk(0, 3'd0, 16'h0, 1, 3'd3, 16'h5555, 0, 0, 1);
        drive_cycle(v, "same1");
        v = mk(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0, 0);
        drive_cycle(v, "same2");
        chk("same.reg3", {16'd0, regs[3]}, 32'h5555);

        // Bulk writes up to 0xFFFF, then one more to wrap
        n = 65535 - int'(exp_count);
        req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 16'hC0DE;
        req1_valid = 1'b0; flush = 1'b0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        exp_count = 16'hFFFF;
        hold_addr = 3'd6; hold_data = 16'hC0DE; hold_gid = 1'b0;
        chk("bulk.count", {16'd0, write_count}, 32'hFFFF);
        v = mk(1, 3'd5, 16'hD00D, 0, 3'd0, 16'h0, 0, 1, 0);
        drive_cycle(v, "wrap");
        chk("wrap.count", {16'd0, write_count}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
